// File: rtl/weight_fetch_sequencer_if.sv
// Weight-side buses of the fetch sequencer: buffer read port and the
// held-word/phase stream that feeds the bit-width MUX and PE array.
interface weight_fetch_sequencer_if #(
    parameter int ADDR_W = 10
);
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [31:0]       rd_data;
    logic [31:0]       buffer_word;
    logic [1:0]        mux_state;
    logic [1:0]        bitwidth_q;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output rd_en, rd_addr, buffer_word, mux_state, bitwidth_q, out_valid,
        input  rd_data, out_ready
    );

    modport slave (
        input  rd_en, rd_addr, buffer_word, mux_state, bitwidth_q, out_valid,
        output rd_data, out_ready
    );
endinterface

// File: rtl/weight_fetch_sequencer.sv
// Fetches 32-bit weight words, holds each one and steps the MUX phase index
// once per accepted beat; phases per word follow the latched bit-width.
module weight_fetch_sequencer #(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic [CNT_W-1:0]     word_count,
    input  logic [1:0]           input_bitwidth,
    weight_fetch_sequencer_if.master bus,
    output logic                 busy,
    output logic                 done
);
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FETCH   = 2'd1,
        S_CAPTURE = 2'd2,
        S_EMIT    = 2'd3
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic [CNT_W-1:0]  r_words_left, w_words_nxt;
    logic [1:0]        r_bw, w_bw_nxt;
    logic              r_rd_en, w_rd_en_nxt;
    logic [31:0]       r_word, w_word_nxt;
    logic [1:0]        r_mux, w_mux_nxt;
    logic              r_valid, w_valid_nxt;
    logic              r_busy, w_busy_nxt;
    logic              r_done, w_done_nxt;
    logic              w_handshake;
    logic              w_last_phase;

    assign w_handshake = r_valid & bus.out_ready;

    // 8-bit words take one phase, 4-bit two, 2-bit (10/11) four.
    always_comb begin
        case (r_bw)
            2'b00:   w_last_phase = (r_mux == 2'd0);
            2'b01:   w_last_phase = (r_mux == 2'd1);
            default: w_last_phase = (r_mux == 2'd3);
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_words_nxt = r_words_left;
        w_bw_nxt    = r_bw;
        w_rd_en_nxt = 1'b0;
        w_word_nxt  = r_word;
        w_mux_nxt   = r_mux;
        w_valid_nxt = r_valid;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (word_count != '0) begin
                        w_addr_nxt  = base_addr;
                        w_words_nxt = word_count;
                        w_bw_nxt    = input_bitwidth;
                        w_rd_en_nxt = 1'b1;
                        w_busy_nxt  = 1'b1;
                        w_state_nxt = S_FETCH;
                    end else begin
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            S_FETCH: begin
                w_state_nxt = S_CAPTURE;
            end
            S_CAPTURE: begin
                w_word_nxt  = bus.rd_data;
                w_mux_nxt   = 2'd0;
                w_valid_nxt = 1'b1;
                w_state_nxt = S_EMIT;
            end
            S_EMIT: begin
                if (w_handshake) begin
                    if (w_last_phase) begin
                        w_mux_nxt   = 2'd0;
                        w_valid_nxt = 1'b0;
                        w_words_nxt = r_words_left - CNT_W'(1);
                        if (r_words_left == CNT_W'(1)) begin
                            w_done_nxt  = 1'b1;
                            w_busy_nxt  = 1'b0;
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_addr_nxt  = r_addr + ADDR_W'(1);
                            w_rd_en_nxt = 1'b1;
                            w_state_nxt = S_FETCH;
                        end
                    end else begin
                        w_mux_nxt = r_mux + 2'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr       <= '0;
            r_words_left <= '0;
            r_bw         <= '0;
            r_rd_en      <= 1'b0;
            r_word       <= '0;
            r_mux        <= '0;
            r_valid      <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_addr       <= w_addr_nxt;
            r_words_left <= w_words_nxt;
            r_bw         <= w_bw_nxt;
            r_rd_en      <= w_rd_en_nxt;
            r_word       <= w_word_nxt;
            r_mux        <= w_mux_nxt;
            r_valid      <= w_valid_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
        end
    end

    assign bus.rd_en       = r_rd_en;
    assign bus.rd_addr     = r_addr;
    assign bus.buffer_word = r_word;
    assign bus.mux_state   = r_mux;
    assign bus.bitwidth_q  = r_bw;
    assign bus.out_valid   = r_valid;
    assign busy            = r_busy;
    assign done            = r_done;
endmodule

// File: tb/tb_weight_fetch_sequencer.sv
// Directed bench for weight_fetch_sequencer: cycle table for streaming runs,
// then hand sequences for backpressure, empty start, wrap and mid-run reset.
module tb_weight_fetch_sequencer;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [9:0] base_addr = '0;
    logic [9:0] word_count = '0;
    logic [1:0] input_bitwidth = '0;
    logic       busy, done;

    logic [31:0] mem [1024];
    int checks = 0;
    int failures = 0;
    int n_reads = 0;

    weight_fetch_sequencer_if #(.ADDR_W(10)) bus ();

    weight_fetch_sequencer #(.ADDR_W(10), .CNT_W(10)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .base_addr      (base_addr),
        .word_count     (word_count),
        .input_bitwidth (input_bitwidth),
        .bus            (bus.master),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    // Buffer model: data valid the cycle after the read strobe.
    always @(posedge clk) begin
        if (bus.rd_en) begin
            bus.rd_data <= mem[bus.rd_addr];
            n_reads <= n_reads + 1;
        end
    end

    typedef struct {
        logic        st;
        logic [9:0]  base;
        logic [9:0]  cnt;
        logic [1:0]  bw;
        logic        rdy;
        logic        e_en;
        logic [9:0]  e_addr;
        logic        e_val;
        logic [1:0]  e_mux;
        logic [31:0] e_word;
        logic [1:0]  e_bwq;
        logic        e_busy;
        logic        e_done;
    } vec_t;

    vec_t tbl [22];

    function automatic vec_t v(logic st, logic [9:0] base, logic [9:0] cnt, logic [1:0] bw,
                               logic en, logic [9:0] addr, logic val, logic [1:0] mux,
                               logic [31:0] word, logic [1:0] bwq, logic bsy, logic dn);
        vec_t r;
        r.st = st; r.base = base; r.cnt = cnt; r.bw = bw; r.rdy = 1'b1;
        r.e_en = en; r.e_addr = addr; r.e_val = val; r.e_mux = mux;
        r.e_word = word; r.e_bwq = bwq; r.e_busy = bsy; r.e_done = dn;
        return r;
    endfunction

    function automatic logic [31:0] w(int unsigned i);
        return 32'hC0DE_0000 | i;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] emux [7];
        logic       rdy  [7];
        int         r0;

        for (int i = 0; i < 1024; i++) mem[i] = w(i);
        mem[0]    = 32'hAABB_CCDD;
        mem[1]    = 32'h1122_3344;
        mem[1023] = 32'hDEAD_BEEF;
        bus.rd_data   = '0;
        bus.out_ready = 1'b1;

        //          st base cnt bw   en addr val mux word          bwq bsy dn
        tbl[0]  = v(1, 5,  3,  0,   0, 0,   0,  0,  0,            0,  0,  0);
        tbl[1]  = v(0, 0,  0,  0,   1, 5,   0,  0,  0,            0,  1,  0);
        tbl[2]  = v(0, 0,  0,  0,   0, 5,   0,  0,  0,            0,  1,  0);
        tbl[3]  = v(0, 0,  0,  0,   0, 5,   1,  0,  w(5),         0,  1,  0);
        tbl[4]  = v(0, 0,  0,  0,   1, 6,   0,  0,  w(5),         0,  1,  0);
        tbl[5]  = v(0, 0,  0,  0,   0, 6,   0,  0,  w(5),         0,  1,  0);
        tbl[6]  = v(0, 0,  0,  0,   0, 6,   1,  0,  w(6),         0,  1,  0);
        tbl[7]  = v(0, 0,  0,  0,   1, 7,   0,  0,  w(6),         0,  1,  0);
        tbl[8]  = v(0, 0,  0,  0,   0, 7,   0,  0,  w(6),         0,  1,  0);
        tbl[9]  = v(0, 0,  0,  0,   0, 7,   1,  0,  w(7),         0,  1,  0);
        tbl[10] = v(0, 0,  0,  0,   0, 7,   0,  0,  w(7),         0,  0,  1);
        tbl[11] = v(1, 0,  2,  1,   0, 7,   0,  0,  w(7),         0,  0,  0);
        tbl[12] = v(0, 0,  0,  0,   1, 0,   0,  0,  w(7),         1,  1,  0);
        tbl[13] = v(0, 0,  0,  0,   0, 0,   0,  0,  w(7),         1,  1,  0);
        tbl[14] = v(0, 0,  0,  0,   0, 0,   1,  0,  32'hAABBCCDD, 1,  1,  0);
        tbl[15] = v(0, 0,  0,  0,   0, 0,   1,  1,  32'hAABBCCDD, 1,  1,  0);
        tbl[16] = v(0, 0,  0,  0,   1, 1,   0,  0,  32'hAABBCCDD, 1,  1,  0);
        tbl[17] = v(0, 0,  0,  0,   0, 1,   0,  0,  32'hAABBCCDD, 1,  1,  0);
        tbl[18] = v(0, 0,  0,  0,   0, 1,   1,  0,  32'h11223344, 1,  1,  0);
        tbl[19] = v(0, 0,  0,  0,   0, 1,   1,  1,  32'h11223344, 1,  1,  0);
        tbl[20] = v(0, 0,  0,  0,   0, 1,   0,  0,  32'h11223344, 1,  0,  1);
        tbl[21] = v(0, 0,  0,  0,   0, 1,   0,  0,  32'h11223344, 1,  0,  0);

        repeat (3) step();
        reset = 1'b0;

        // Streaming runs: bw=00 base 5 x3, then bw=01 base 0 x2
        for (int i = 0; i < 22; i++) begin
            step();
            start          = tbl[i].st;
            base_addr      = tbl[i].base;
            word_count     = tbl[i].cnt;
            input_bitwidth = tbl[i].bw;
            bus.out_ready  = tbl[i].rdy;
            chk($sformatf("t%0d.rd_en", i),     32'(bus.rd_en),     32'(tbl[i].e_en));
            chk($sformatf("t%0d.rd_addr", i),   32'(bus.rd_addr),   32'(tbl[i].e_addr));
            chk($sformatf("t%0d.out_valid", i), 32'(bus.out_valid), 32'(tbl[i].e_val));
            chk($sformatf("t%0d.mux_state", i), 32'(bus.mux_state), 32'(tbl[i].e_mux));
            chk($sformatf("t%0d.word", i),      bus.buffer_word,    tbl[i].e_word);
            chk($sformatf("t%0d.bwq", i),       32'(bus.bitwidth_q), 32'(tbl[i].e_bwq));
            chk($sformatf("t%0d.busy", i),      32'(busy),          32'(tbl[i].e_busy));
            chk($sformatf("t%0d.done", i),      32'(done),          32'(tbl[i].e_done));
        end

        // Backpressure on a 2-bit word: phases advance only on handshakes
        emux = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3};
        rdy  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        step();
        start = 1'b1; base_addr = 10'd9; word_count = 10'd1; input_bitwidth = 2'b10;
        bus.out_ready = 1'b0;
        step();
        start = 1'b0;
        chk("bp.fetch_en", 32'(bus.rd_en), 32'd1);
        chk("bp.fetch_addr", 32'(bus.rd_addr), 32'd9);
        step();
        chk("bp.capture_valid", 32'(bus.out_valid), 32'd0);
        for (int k = 0; k < 7; k++) begin
            step();
            chk($sformatf("bp%0d.valid", k), 32'(bus.out_valid), 32'd1);
            chk($sformatf("bp%0d.mux", k),   32'(bus.mux_state), 32'(emux[k]));
            chk($sformatf("bp%0d.word", k),  bus.buffer_word,    w(9));
            chk($sformatf("bp%0d.bwq", k),   32'(bus.bitwidth_q), 32'd2);
            bus.out_ready = rdy[k];
        end
        step();
        chk("bp.done", 32'(done), 32'd1);
        chk("bp.busy", 32'(busy), 32'd0);
        chk("bp.valid_low", 32'(bus.out_valid), 32'd0);
        chk("bp.mux_reset", 32'(bus.mux_state), 32'd0);

        // Empty request: done pulse only
        bus.out_ready = 1'b1;
        r0 = n_reads;
        start = 1'b1; base_addr = 10'd40; word_count = 10'd0; input_bitwidth = 2'b00;
        step();
        start = 1'b0;
        chk("zero.done", 32'(done), 32'd1);
        chk("zero.busy", 32'(busy), 32'd0);
        chk("zero.rd_en", 32'(bus.rd_en), 32'd0);
        step();
        chk("zero.done_clear", 32'(done), 32'd0);
        chk("zero.busy2", 32'(busy), 32'd0);
        chk("zero.reads", 32'(n_reads - r0), 32'd0);

        // Address wrap with an ignored start while busy
        r0 = n_reads;
        start = 1'b1; base_addr = 10'd1023; word_count = 10'd2; input_bitwidth = 2'b00;
        step();
        start = 1'b1; base_addr = 10'd100; word_count = 10'd5; input_bitwidth = 2'b01;
        chk("wrap.en0", 32'(bus.rd_en), 32'd1);
        chk("wrap.addr0", 32'(bus.rd_addr), 32'd1023);
        step();
        start = 1'b0;
        step();
        chk("wrap.word0", bus.buffer_word, 32'hDEADBEEF);
        chk("wrap.valid0", 32'(bus.out_valid), 32'd1);
        chk("wrap.bwq", 32'(bus.bitwidth_q), 32'd0);
        step();
        chk("wrap.en1", 32'(bus.rd_en), 32'd1);
        chk("wrap.addr1", 32'(bus.rd_addr), 32'd0);
        step();
        step();
        chk("wrap.word1", bus.buffer_word, 32'hAABBCCDD);
        step();
        chk("wrap.done", 32'(done), 32'd1);
        chk("wrap.busy", 32'(busy), 32'd0);
        step();
        chk("wrap.reads", 32'(n_reads - r0), 32'd2);
        chk("wrap.idle_en", 32'(bus.rd_en), 32'd0);

        // Reset during phase 2 of a 2-bit word, then a clean restart
        start = 1'b1; base_addr = 10'd20; word_count = 10'd3; input_bitwidth = 2'b10;
        step();
        start = 1'b0;
        repeat (4) step();
        chk("rst.pre_mux", 32'(bus.mux_state), 32'd2);
        reset = 1'b1;
        #1;
        chk("rst.rd_en", 32'(bus.rd_en), 32'd0);
        chk("rst.rd_addr", 32'(bus.rd_addr), 32'd0);
        chk("rst.word", bus.buffer_word, 32'd0);
        chk("rst.mux", 32'(bus.mux_state), 32'd0);
        chk("rst.bwq", 32'(bus.bitwidth_q), 32'd0);
        chk("rst.valid", 32'(bus.out_valid), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        step();
        reset = 1'b0;
        step();
        step();
        chk("rst.idle_busy", 32'(busy), 32'd0);
        chk("rst.idle_en", 32'(bus.rd_en), 32'd0);
        chk("rst.idle_valid", 32'(bus.out_valid), 32'd0);
        start = 1'b1; base_addr = 10'd3; word_count = 10'd1; input_bitwidth = 2'b10;
        step();
        start = 1'b0;
        chk("re.en", 32'(bus.rd_en), 32'd1);
        chk("re.addr", 32'(bus.rd_addr), 32'd3);
        step();
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("re%0d.valid", k), 32'(bus.out_valid), 32'd1);
            chk($sformatf("re%0d.mux", k),   32'(bus.mux_state), 32'(k));
            chk($sformatf("re%0d.word", k),  bus.buffer_word,    w(3));
        end
        step();
        chk("re.done", 32'(done), 32'd1);
        chk("re.busy", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/weight_fetch_sequencer.md
# weight_fetch_sequencer

Clocked control stage directly upstream of the weight-side bit-width MUX. It reads 32-bit words from the weight buffer, holds each word stable, and steps the 2-bit phase index (`mux_state`) that selects which byte slices the MUX replicates. The number of phases per word follows the latched input bit-width. A valid/ready handshake paces delivery to the PE array, so the MUX stays purely combinational.

## Interface
- ADDR_W, 10, weight buffer address width
- CNT_W, 10, width of the word-count field

- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state and outputs
- start  input  1  single-cycle request to begin a fetch sequence; sampled only in IDLE
- base_addr  input  ADDR_W  first buffer address; latched on accepted start
- word_count  input  CNT_W  number of 32-bit words to stream; latched on accepted start
- input_bitwidth  input  2  00 = 8-bit, 01 = 4-bit, 10/11 = 2-bit; latched on accepted start
- rd_en  output  1  buffer read strobe, registered
- rd_addr  output  ADDR_W  buffer read address, registered
- rd_data  input  32  buffer read data, valid the cycle after rd_en=1
- buffer_word  output  32  held word, drives the MUX buffer input
- mux_state  output  2  phase index, drives the MUX state input
- bitwidth_q  output  2  latched input_bitwidth, drives the MUX input_bitwidth input
- out_valid  output  1  buffer_word/mux_state form a valid beat
- out_ready  input  1  consumer accepts the beat
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle pulse at sequence completion

## Operation
- FSM states: IDLE, FETCH, CAPTURE, EMIT.
- IDLE with start=1 and word_count≠0:
  - latch base_addr, word_count and input_bitwidth into the address register, words_left and bitwidth_q
  - go to FETCH; busy=1
- IDLE with start=1 and word_count=0:
  - pulse done next cycle
  - no rd_en; remain IDLE
- FETCH: rd_en=1, rd_addr=current address; go to CAPTURE.
- CAPTURE: buffer_word <= rd_data; mux_state <= 0; go to EMIT.
- EMIT: out_valid=1. Each handshake is out_valid & out_ready.
- Phases per word: P=1 for 00, P=2 for 01, P=4 for 10/11.
- On a handshake with mux_state < P-1: mux_state increments.
- On a handshake with mux_state = P-1:
  - mux_state <= 0; words_left decrements
  - if words_left was 1: go to IDLE, done=1 for one cycle, busy=0
  - otherwise: address increments, go to FETCH
- Address arithmetic is modulo 2^ADDR_W; 2^ADDR_W-1 wraps to 0.
- start while busy is ignored; the latched config does not change mid-sequence.
- With out_ready low, buffer_word, mux_state and out_valid hold their values.
- buffer_word is not cleared between words; it changes only in CAPTURE.

## Timing
- Reset values: rd_en=0, rd_addr=0, buffer_word=0, mux_state=0, bitwidth_q=0, out_valid=0, busy=0, done=0; state=IDLE.
- start sampled at edge 0:
  - cycle 1: FETCH, rd_en=1
  - cycle 2: CAPTURE, rd_data present
  - cycle 3: first out_valid=1
- Word-to-word gap: 2 cycles with out_valid=0 (FETCH, CAPTURE) after the last-phase handshake.
- Sustained throughput with out_ready=1: P beats per P+2 cycles.
- done is high in the cycle after the final handshake; busy falls in the same cycle.
- Reset asserted mid-sequence:
  - all outputs go to reset values immediately (asynchronous)
  - the in-flight read is discarded
  - after reset deasserts, the block waits in IDLE for a new start

## Test plan
- bw=00, base=5, count=3, out_ready=1 -> rd_addr 5,6,7; three beats, each with mux_state=0 and buffer_word equal to the corresponding buffer contents; done one cycle after the 3rd beat.
- bw=01, base=0, count=2, buffer {0xAABBCCDD, 0x11223344} -> four beats, mux_state 0,1,0,1; buffer_word 0xAABBCCDD for beats 1–2 and 0x11223344 for beats 3–4.
- bw=10, count=1, out_ready toggled 1,0,0,1,... -> mux_state 0,1,2,3 advancing only on handshakes; out_valid, buffer_word and mux_state stable while out_ready=0.
- start with word_count=0 -> done pulse next cycle, rd_en never asserted, busy stays 0.
- base=1023, count=2 (ADDR_W=10) -> rd_addr 1023 then 0; start pulsed during busy -> ignored, exactly 2 reads.
- reset asserted during EMIT on phase 2 of a bw=10 word -> all outputs 0 the same cycle; after release, a new start with count=1 runs normally from mux_state=0.
